// File: rtl/spi_sclk_gen_mode_pkg.sv
// Shared constants, state encoding and strobe decode for the SPI serial-clock
// generator and its datapath neighbours.
package spi_sclk_gen_mode_pkg;

  localparam int unsigned SPI_DIVIDER_LEN = 8;

  typedef enum logic [1:0] {
    SPI_CLK_IDLE  = 2'd0,
    SPI_CLK_SETUP = 2'd1,
    SPI_CLK_RUN   = 2'd2,
    SPI_CLK_HOLD  = 2'd3
  } spi_clk_state_e;

  // SPI modes as {cpol, cpha}
  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;

  typedef struct packed {
    logic sample;
    logic shift;
  } spi_strobe_t;

  // Leading edges are odd-numbered. With cpha=0 data is captured on the
  // leading edge and advanced on the trailing edge (except the final one,
  // since the first bit is already presented at CS assertion). With cpha=1
  // data is advanced on the leading edge and captured on the trailing edge.
  function automatic spi_strobe_t spi_edge_strobes(input logic cpha,
                                                   input logic leading,
                                                   input logic last_edge);
    spi_strobe_t s;
    s = '0;
    if (!cpha) begin
      s.sample = leading;
      s.shift  = !leading && !last_edge;
    end else begin
      s.shift  = leading;
      s.sample = !leading;
    end
    return s;
  endfunction

endpackage

// File: rtl/spi_sclk_gen_mode_if.sv
// Control/status bundle between the SPI register block, the clock generator
// and the shift-register datapath.
interface spi_sclk_gen_mode_if
  import spi_sclk_gen_mode_pkg::*;
#(
  parameter int unsigned DIV_W = SPI_DIVIDER_LEN,
  parameter int unsigned CNT_W = 6
);

  logic             i_enable;
  logic             i_tx_start;
  logic             i_cpol;
  logic             i_cpha;
  logic [DIV_W-1:0] i_divider;
  logic [CNT_W-1:0] i_bit_cnt;

  logic             o_sclk;
  logic             o_pos_edge;
  logic             o_neg_edge;
  logic             o_sample;
  logic             o_shift;
  logic             o_busy;
  logic             o_done;
  logic             o_cs_n;

  // Register-block side: issues configuration and start, observes status
  modport master (
    output i_enable, i_tx_start, i_cpol, i_cpha, i_divider, i_bit_cnt,
    input  o_sclk, o_pos_edge, o_neg_edge, o_sample, o_shift,
           o_busy, o_done, o_cs_n
  );

  // Clock-generator side
  modport slave (
    input  i_enable, i_tx_start, i_cpol, i_cpha, i_divider, i_bit_cnt,
    output o_sclk, o_pos_edge, o_neg_edge, o_sample, o_shift,
           o_busy, o_done, o_cs_n
  );

endinterface

// File: rtl/spi_sclk_gen_mode_half_period_cnt.sv
// Loadable modulo-(max+1) counter with terminal-count flag. Used for the SCLK
// half-period here and for the slave-side oversampler.
module spi_half_period_cnt #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] max,
  output logic         tc
);

  logic [W-1:0] cnt_q;

  // Count 0..max and wrap; clr restarts the count at zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      if (cnt_q == max) cnt_q <= '0;
      else              cnt_q <= cnt_q + 1'b1;
    end
  end

  // Terminal count is left ungated so the caller can qualify it by state
  // without a combinational loop through the enable
  assign tc = (cnt_q == max);

endmodule

// File: rtl/spi_sclk_gen_mode.sv
// SPI serial-clock generator with CPOL/CPHA modes, programmable transfer
// length, chip-select setup/hold and per-bit sample/shift strobes.
module spi_sclk_gen_mode
  import spi_sclk_gen_mode_pkg::*;
#(
  parameter int unsigned DIV_W    = SPI_DIVIDER_LEN,
  parameter int unsigned CNT_W    = 6,
  parameter int unsigned CS_SETUP = 2,
  parameter int unsigned CS_HOLD  = 2
) (
  input logic                i_clk,
  input logic                i_rst_n,
  spi_sclk_gen_mode_if.slave bus
);

  localparam int unsigned WAIT_MAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int unsigned WAIT_W   = $clog2(WAIT_MAX) + 1;
  localparam logic [WAIT_W-1:0] SETUP_LAST = WAIT_W'(CS_SETUP - 1);
  localparam logic [WAIT_W-1:0] HOLD_LAST  = WAIT_W'(CS_HOLD - 1);

  spi_clk_state_e    state_q, state_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              cpol_q, cpol_d;
  logic              cpha_q, cpha_d;
  logic [CNT_W:0]    edge_q, edge_d;
  logic [CNT_W:0]    next_edge;
  logic              last_edge;
  logic [WAIT_W-1:0] wait_q, wait_d;

  logic              sclk_q, sclk_d;
  logic              pos_q, pos_d;
  logic              neg_q, neg_d;
  spi_strobe_t       strobe_q, strobe_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              cs_n_q, cs_n_d;

  logic              phase_clr;
  logic              phase_en;
  logic              phase_tc;
  logic              start_ok;

  spi_half_period_cnt #(
    .W (DIV_W)
  ) u_phase (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .clr   (phase_clr),
    .en    (phase_en),
    .max   (div_q),
    .tc    (phase_tc)
  );

  assign next_edge = edge_q + 1'b1;
  assign last_edge = (next_edge == {cnt_q, 1'b0});
  assign start_ok  = bus.i_tx_start && bus.i_enable && (bus.i_bit_cnt != '0);

  // State register and registered outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= SPI_CLK_IDLE;
      div_q    <= '0;
      cnt_q    <= '0;
      cpol_q   <= 1'b0;
      cpha_q   <= 1'b0;
      edge_q   <= '0;
      wait_q   <= '0;
      sclk_q   <= 1'b0;
      pos_q    <= 1'b0;
      neg_q    <= 1'b0;
      strobe_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      cs_n_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      cnt_q    <= cnt_d;
      cpol_q   <= cpol_d;
      cpha_q   <= cpha_d;
      edge_q   <= edge_d;
      wait_q   <= wait_d;
      sclk_q   <= sclk_d;
      pos_q    <= pos_d;
      neg_q    <= neg_d;
      strobe_q <= strobe_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      cs_n_q   <= cs_n_d;
    end
  end

  // Next-state and next-output decode
  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    cnt_d     = cnt_q;
    cpol_d    = cpol_q;
    cpha_d    = cpha_q;
    edge_d    = edge_q;
    wait_d    = wait_q;
    sclk_d    = sclk_q;
    pos_d     = 1'b0;
    neg_d     = 1'b0;
    strobe_d  = '0;
    busy_d    = busy_q;
    done_d    = 1'b0;
    cs_n_d    = cs_n_q;
    phase_clr = 1'b1;
    phase_en  = 1'b0;

    case (state_q)
      SPI_CLK_IDLE: begin
        sclk_d = bus.i_cpol;
        busy_d = 1'b0;
        cs_n_d = 1'b1;
        if (start_ok) begin
          div_d   = bus.i_divider;
          cnt_d   = bus.i_bit_cnt;
          cpol_d  = bus.i_cpol;
          cpha_d  = bus.i_cpha;
          edge_d  = '0;
          wait_d  = '0;
          busy_d  = 1'b1;
          cs_n_d  = 1'b0;
          state_d = SPI_CLK_SETUP;
        end
      end

      SPI_CLK_SETUP: begin
        sclk_d = cpol_q;
        if (wait_q == SETUP_LAST) begin
          wait_d  = '0;
          state_d = SPI_CLK_RUN;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end

      SPI_CLK_RUN: begin
        phase_clr = 1'b0;
        phase_en  = 1'b1;
        if (phase_tc) begin
          sclk_d   = ~sclk_q;
          pos_d    = ~sclk_q;
          neg_d    = sclk_q;
          edge_d   = next_edge;
          strobe_d = spi_edge_strobes(cpha_q, next_edge[0], last_edge);
          if (last_edge) begin
            wait_d  = '0;
            state_d = SPI_CLK_HOLD;
          end
        end
      end

      SPI_CLK_HOLD: begin
        if (wait_q == HOLD_LAST) begin
          wait_d  = '0;
          busy_d  = 1'b0;
          cs_n_d  = 1'b1;
          done_d  = 1'b1;
          state_d = SPI_CLK_IDLE;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end

      default: begin
        state_d = SPI_CLK_IDLE;
      end
    endcase

    // Abort overrides every transition above: release CS and park SCLK
    if ((state_q != SPI_CLK_IDLE) && !bus.i_enable) begin
      state_d   = SPI_CLK_IDLE;
      sclk_d    = cpol_q;
      pos_d     = 1'b0;
      neg_d     = 1'b0;
      strobe_d  = '0;
      busy_d    = 1'b0;
      done_d    = 1'b0;
      cs_n_d    = 1'b1;
      edge_d    = '0;
      wait_d    = '0;
      phase_clr = 1'b1;
      phase_en  = 1'b0;
    end
  end

  assign bus.o_sclk     = sclk_q;
  assign bus.o_pos_edge = pos_q;
  assign bus.o_neg_edge = neg_q;
  assign bus.o_sample   = strobe_q.sample;
  assign bus.o_shift    = strobe_q.shift;
  assign bus.o_busy     = busy_q;
  assign bus.o_done     = done_q;
  assign bus.o_cs_n     = cs_n_q;

endmodule

// File: tb/tb_spi_sclk_gen_mode.sv
// Self-checking bench for spi_sclk_gen_mode: table of transfers with
// per-transfer expectations queued at start and compared at o_done, plus
// hand-written abort, reset and zero-length sequences.
module tb_spi_sclk_gen_mode;
  import spi_sclk_gen_mode_pkg::*;

  localparam int unsigned DIV_W    = 8;
  localparam int unsigned CNT_W    = 6;
  localparam int unsigned CS_SETUP = 2;
  localparam int unsigned CS_HOLD  = 2;
  localparam int NVEC = 10;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  spi_sclk_gen_mode_if #(.DIV_W(DIV_W), .CNT_W(CNT_W)) bus ();

  spi_sclk_gen_mode #(
    .DIV_W    (DIV_W),
    .CNT_W    (CNT_W),
    .CS_SETUP (CS_SETUP),
    .CS_HOLD  (CS_HOLD)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  typedef struct {
    logic [1:0] mode;
    int div;
    int bits;
    int poke;       // edge number at which inputs are disturbed (0 = none)
    int e_busy;
    int e_pos;
    int e_neg;
    int e_smp_pos;
    int e_smp_neg;
    int e_sh_pos;
    int e_sh_neg;
    int e_half;
  } vec_t;

  vec_t vecs[NVEC];
  vec_t exp_q[$];
  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", name, act, exp);
  endtask

  // Drives one transfer starting at the current negedge and returns at the
  // negedge where o_done is seen, so a following call starts back-to-back.
  task automatic run_transfer(input vec_t v, input int idx);
    vec_t e;
    int busy_cnt, pos, neg, smp_pos, smp_neg, sh_pos, sh_neg;
    int edges, first_edge, last_edge, min_iv, max_iv, cs_bad, stray;
    int got_done, first_busy, first_done, sclk_end, csn_end, busy_end;
    logic pulse;
    busy_cnt = 0; pos = 0; neg = 0; smp_pos = 0; smp_neg = 0; sh_pos = 0; sh_neg = 0;
    edges = 0; first_edge = 0; last_edge = 0; min_iv = 1 << 30; max_iv = 0;
    cs_bad = 0; stray = 0; got_done = 0; first_busy = 0; first_done = 1;
    sclk_end = -1; csn_end = -1; busy_end = -1;

    bus.i_cpol     = v.mode[1];
    bus.i_cpha     = v.mode[0];
    bus.i_divider  = DIV_W'(v.div);
    bus.i_bit_cnt  = CNT_W'(v.bits);
    bus.i_tx_start = 1'b1;
    exp_q.push_back(v);
    @(negedge clk);
    bus.i_tx_start = 1'b0;

    for (int c = 0; c < 4000; c++) begin
      if (c == 0) begin
        first_busy = int'(bus.o_busy);
        first_done = int'(bus.o_done);
      end
      if (bus.o_done) begin
        got_done = 1;
        sclk_end = int'(bus.o_sclk);
        csn_end  = int'(bus.o_cs_n);
        busy_end = int'(bus.o_busy);
        break;
      end
      if (bus.o_busy) busy_cnt++;
      if (bus.o_cs_n == bus.o_busy) cs_bad++;
      if ((bus.o_pos_edge && !bus.o_sclk) || (bus.o_neg_edge && bus.o_sclk) ||
          (bus.o_pos_edge && bus.o_neg_edge) ||
          ((bus.o_sample || bus.o_shift) && !(bus.o_pos_edge || bus.o_neg_edge)))
        stray++;
      pulse = 1'b0;
      if (bus.o_pos_edge) begin
        pos++;
        if (bus.o_sample) smp_pos++;
        if (bus.o_shift) sh_pos++;
      end
      if (bus.o_neg_edge) begin
        neg++;
        if (bus.o_sample) smp_neg++;
        if (bus.o_shift) sh_neg++;
      end
      if (bus.o_pos_edge || bus.o_neg_edge) begin
        edges++;
        if (edges == 1) first_edge = busy_cnt;
        else begin
          if (busy_cnt - last_edge < min_iv) min_iv = busy_cnt - last_edge;
          if (busy_cnt - last_edge > max_iv) max_iv = busy_cnt - last_edge;
        end
        last_edge = busy_cnt;
        if (v.poke != 0 && edges == v.poke) begin
          bus.i_divider = 8'd12;
          bus.i_bit_cnt = 6'd3;
          bus.i_cpol    = ~bus.i_cpol;
          bus.i_cpha    = ~bus.i_cpha;
          pulse = 1'b1;
        end
      end
      bus.i_tx_start = pulse;
      @(negedge clk);
    end
    bus.i_tx_start = 1'b0;

    e = exp_q.pop_front();
    check($sformatf("v%0d_done_seen", idx), got_done, 1);
    check($sformatf("v%0d_first_busy", idx), first_busy, 1);
    check($sformatf("v%0d_first_nodone", idx), first_done, 0);
    check($sformatf("v%0d_busy_cycles", idx), busy_cnt, e.e_busy);
    check($sformatf("v%0d_pos", idx), pos, e.e_pos);
    check($sformatf("v%0d_neg", idx), neg, e.e_neg);
    check($sformatf("v%0d_sample_pos", idx), smp_pos, e.e_smp_pos);
    check($sformatf("v%0d_sample_neg", idx), smp_neg, e.e_smp_neg);
    check($sformatf("v%0d_shift_pos", idx), sh_pos, e.e_sh_pos);
    check($sformatf("v%0d_shift_neg", idx), sh_neg, e.e_sh_neg);
    check($sformatf("v%0d_first_edge", idx), first_edge, int'(CS_SETUP) + e.e_half + 1);
    check($sformatf("v%0d_last_edge", idx), last_edge, e.e_busy - int'(CS_HOLD) + 1);
    check($sformatf("v%0d_half_min", idx), min_iv, e.e_half);
    check($sformatf("v%0d_half_max", idx), max_iv, e.e_half);
    check($sformatf("v%0d_sclk_end", idx), sclk_end, int'(e.mode[1]));
    check($sformatf("v%0d_cs_n_end", idx), csn_end, 1);
    check($sformatf("v%0d_busy_end", idx), busy_end, 0);
    check($sformatf("v%0d_cs_vs_busy", idx), cs_bad, 0);
    check($sformatf("v%0d_stray_strobe", idx), stray, 0);
  endtask

  initial begin
    int edges, hit, bad;

    //            mode       div bits poke busy pos neg sp sn hp hn half
    vecs[0] = '{SPI_MODE0,   2,   8,  0,  52,   8,  8, 8, 0, 0, 7,   3};
    vecs[1] = '{SPI_MODE3,   0,   4,  0,  12,   4,  4, 4, 0, 0, 4,   1};
    vecs[2] = '{SPI_MODE0,   2,   8,  5,  52,   8,  8, 8, 0, 0, 7,   3};
    vecs[3] = '{SPI_MODE0,  12,   2,  0,  56,   2,  2, 2, 0, 0, 1,  13};
    vecs[4] = '{SPI_MODE0,   3,   3,  0,  28,   3,  3, 3, 0, 0, 2,   4};
    vecs[5] = '{SPI_MODE1,   1,   5,  0,  24,   5,  5, 0, 5, 5, 0,   2};
    vecs[6] = '{SPI_MODE2,   4,   2,  0,  24,   2,  2, 0, 2, 1, 0,   5};
    vecs[7] = '{SPI_MODE0, 255,   1,  0, 516,   1,  1, 1, 0, 0, 0, 256};
    vecs[8] = '{SPI_MODE0,   0,  63,  0, 130,  63, 63,63, 0, 0,62,   1};
    vecs[9] = '{SPI_MODE1,   0,   1,  0,   6,   1,  1, 0, 1, 1, 0,   1};

    rst_n          = 1'b0;
    bus.i_enable   = 1'b1;
    bus.i_tx_start = 1'b0;
    bus.i_cpol     = 1'b1;
    bus.i_cpha     = 1'b0;
    bus.i_divider  = '0;
    bus.i_bit_cnt  = '0;
    repeat (2) @(negedge clk);
    check("rst_sclk", int'(bus.o_sclk), 0);
    check("rst_cs_n", int'(bus.o_cs_n), 1);
    check("rst_busy", int'(bus.o_busy), 0);
    check("rst_done", int'(bus.o_done), 0);
    check("rst_strobes", int'({bus.o_pos_edge, bus.o_neg_edge, bus.o_sample, bus.o_shift}), 0);
    bus.i_cpol = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    // Consecutive transfers, each started in the previous one's done cycle
    for (int i = 0; i < NVEC; i++) run_transfer(vecs[i], i);

    // Done is a single-cycle pulse
    @(negedge clk);
    check("done_one_cycle", int'(bus.o_done), 0);

    // Idle SCLK follows i_cpol
    bus.i_cpol = 1'b1;
    @(negedge clk);
    check("idle_cpol1", int'(bus.o_sclk), 1);
    bus.i_cpol = 1'b0;
    @(negedge clk);
    check("idle_cpol0", int'(bus.o_sclk), 0);

    // Zero-length start is ignored
    bus.i_bit_cnt  = '0;
    bus.i_tx_start = 1'b1;
    @(negedge clk);
    bus.i_tx_start = 1'b0;
    bad = 0;
    for (int c = 0; c < 4; c++) begin
      if (bus.o_busy || !bus.o_cs_n || bus.o_done) bad++;
      @(negedge clk);
    end
    check("zero_bits_ignored", bad, 0);

    // Abort with i_enable low after edge 7 (mode 2, SCLK reads 0 there)
    bus.i_cpol     = 1'b1;
    bus.i_cpha     = 1'b0;
    bus.i_divider  = 8'd1;
    bus.i_bit_cnt  = 6'd8;
    bus.i_tx_start = 1'b1;
    @(negedge clk);
    bus.i_tx_start = 1'b0;
    edges = 0; hit = 0;
    for (int c = 0; c < 400; c++) begin
      if (bus.o_pos_edge || bus.o_neg_edge) edges++;
      if (edges == 7) begin hit = 1; break; end
      @(negedge clk);
    end
    check("abort_reach_edge7", hit, 1);
    check("abort_sclk_before", int'(bus.o_sclk), 0);
    bus.i_enable = 1'b0;
    @(negedge clk);
    check("abort_cs_n", int'(bus.o_cs_n), 1);
    check("abort_busy", int'(bus.o_busy), 0);
    check("abort_sclk", int'(bus.o_sclk), 1);
    check("abort_done", int'(bus.o_done), 0);
    check("abort_strobes", int'({bus.o_pos_edge, bus.o_neg_edge, bus.o_sample, bus.o_shift}), 0);
    bus.i_enable = 1'b1;
    bad = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (bus.o_done || bus.o_busy) bad++;
    end
    check("abort_no_done_after", bad, 0);

    // Asynchronous reset mid-RUN, with SCLK high (mode 2 after two edges)
    bus.i_divider  = 8'd2;
    bus.i_bit_cnt  = 6'd4;
    bus.i_tx_start = 1'b1;
    @(negedge clk);
    bus.i_tx_start = 1'b0;
    edges = 0; hit = 0;
    for (int c = 0; c < 400; c++) begin
      if (bus.o_pos_edge || bus.o_neg_edge) edges++;
      if (edges == 2) begin hit = 1; break; end
      @(negedge clk);
    end
    check("arst_reach_edge2", hit, 1);
    check("arst_sclk_before", int'(bus.o_sclk), 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_sclk", int'(bus.o_sclk), 0);
    check("arst_cs_n", int'(bus.o_cs_n), 1);
    check("arst_busy", int'(bus.o_busy), 0);
    check("arst_strobes", int'({bus.o_pos_edge, bus.o_neg_edge, bus.o_sample, bus.o_shift}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("arst_idle_cpol", int'(bus.o_sclk), 1);
    check("arst_idle_busy", int'(bus.o_busy), 0);

    // Recovery after reset
    run_transfer(vecs[9], 10);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/spi_sclk_gen_mode.md
Name: spi_sclk_gen_mode

Overview:
Parametrised successor to the SPI serial-clock generator. It adds CPOL/CPHA mode support, a programmable transfer length, and chip-select setup/hold timing. It also provides per-bit sample/shift strobes and busy/done status. The block sits between the SPI control registers and the shift-register datapath of the universal SPI master.

Parameters:
DIV_W, 8, width of i_divider (matches SPI_DIVIDER_LEN in define.v)
CNT_W, 6, width of i_bit_cnt; a transfer is 1..2^CNT_W-1 bits
CS_SETUP, 2, system cycles from o_cs_n falling to the SCLK phase counter starting; minimum 1
CS_HOLD, 2, system cycles from the final SCLK edge to o_cs_n rising; minimum 1

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  asynchronous active-low reset
i_enable  in  1  block enable; low aborts any transfer synchronously
i_tx_start  in  1  start request, sampled only in IDLE
i_cpol  in  1  SCLK idle level
i_cpha  in  1  0: sample on the leading edge; 1: sample on the trailing edge
i_divider  in  DIV_W  SCLK half-period minus one, in i_clk cycles
i_bit_cnt  in  CNT_W  number of SCLK cycles (bits) in the transfer
o_sclk  out  1  serial clock
o_pos_edge  out  1  one-cycle pulse, high in the first cycle o_sclk reads 1
o_neg_edge  out  1  one-cycle pulse, high in the first cycle o_sclk reads 0
o_sample  out  1  strobe: datapath captures MISO
o_shift  out  1  strobe: datapath advances MOSI
o_busy  out  1  transfer in progress
o_done  out  1  one-cycle pulse at normal completion
o_cs_n  out  1  active-low chip select

Behaviour:
- Reset (async, i_rst_n=0) values: state IDLE, o_sclk=0, all strobes 0, o_busy=0, o_done=0, o_cs_n=1, internal counters 0.
- All outputs are registered.
- States: IDLE, SETUP, RUN, HOLD.
- IDLE:
  - o_sclk follows i_cpol, registered.
  - Start condition: i_tx_start=1, i_enable=1 and i_bit_cnt!=0.
  - On start, latch div_q, cnt_q, cpol_q and cpha_q, then go to SETUP.
  - From the next cycle, o_busy=1 and o_cs_n=0.
  - A start with i_bit_cnt=0 is ignored with no outputs changed.
- SETUP: stay exactly CS_SETUP cycles, then go to RUN with the phase counter at 0.
- RUN:
  - The phase counter counts 0..div_q.
  - At terminal count, o_sclk toggles in the next registered cycle and the counter wraps to 0.
  - Half-period is div_q+1 cycles; duty is exactly 50% for every divider value, odd or even.
  - The edge counter counts toggles; RUN ends after 2*cnt_q edges, and o_sclk then equals cpol_q.
- Leading edges are odd-numbered and trailing edges are even-numbered.
  - CPHA=0: o_sample on every leading edge; o_shift on every trailing edge except the last (cnt_q-1 shifts). The first bit is presented at CS assertion.
  - CPHA=1: o_shift on every leading edge (cnt_q shifts); o_sample on every trailing edge.
  - Strobes coincide with the corresponding o_pos_edge/o_neg_edge cycle.
- HOLD: stay CS_HOLD cycles after the final edge cycle, then go to IDLE.
  - In the IDLE-entry cycle: o_cs_n=1, o_busy=0, o_done=1 for one cycle.
- Mid-transfer changes to i_divider, i_bit_cnt, i_cpol and i_cpha have no effect; they apply at the next start.
- i_tx_start while o_busy=1 is ignored and not queued.
- i_enable=0 in any non-IDLE state: next cycle goes to IDLE with o_cs_n=1, o_sclk=cpol_q, strobes 0, o_busy=0 and no o_done.
- Async reset mid-transfer forces the reset values immediately.
- Back-to-back transfers: a start in the same cycle o_done is high is accepted; there is a minimum of one idle cycle with o_cs_n=1.
- Transfer length in cycles: o_busy high for CS_SETUP + 2*cnt_q*(div_q+1) + CS_HOLD cycles.

Decomposition:
- Shared package/define file holds:
  - SPI_DIVIDER_LEN
  - state encodings SPI_CLK_IDLE/SETUP/RUN/HOLD
  - mode constants SPI_MODE0..3 as {cpol,cpha}
- One natural sub-module, spi_half_period_cnt: loadable modulo-(div_q+1) counter with terminal-count output, shared with the later slave-side oversampler.

Test Plan:
All scenarios use DIV_W=8, CNT_W=6, CS_SETUP=2, CS_HOLD=2.
1. Mode 0, div=2, bits=8 -> SCLK period 6 cycles; 8 pos and 8 neg pulses; 8 o_sample on pos edges; 7 o_shift; o_busy 52 cycles; o_sclk idles 0; single o_done.
2. Mode 3, div=0, bits=4 -> SCLK idles 1 and toggles every cycle; first edge falling with o_shift; 4 shifts on falling edges, 4 samples on rising edges; o_busy 12 cycles.
3. Start with div=2, change i_divider to 12 at edge 5 -> period stays 6 to the end; the next start gives period 26, and div=3 gives period 8 with 4/4 duty.
4. Drop i_enable during RUN at edge 7 -> next cycle o_cs_n=1, o_busy=0, o_sclk=cpol, no o_done. Separately, pulse i_tx_start mid-transfer -> no effect.
5. Assert i_rst_n=0 asynchronously mid-RUN -> o_sclk=0, o_cs_n=1, o_busy=0 before the next clock edge. A start with bits=0 -> o_busy stays 0.
6. Back-to-back: re-assert start in the o_done cycle with mode 1, bits=1 -> one idle cycle with o_cs_n=1, then a 1-bit transfer: 1 shift (leading), 1 sample (trailing), 2 edges.
